// File: rtl/stream_demux_1xn_if.sv
// Stream demux handshake bundle: one input stream and N output channels.
// master = producer/consumer side, slave = demux side.
interface stream_demux_1xn_if #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    localparam int SEL_W = $clog2(N);

    logic [WIDTH-1:0]   in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_bcast;
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ready;
    logic [CNT_W-1:0]   drop_cnt;

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_cnt
    );

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_cnt
    );
endinterface

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux with per-channel 1-entry output registers.
// Broadcast is all-or-nothing; out-of-range selects are dropped and counted.
module stream_demux_1xn #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    stream_demux_1xn_if.slave bus
);
    localparam int SEL_W = $clog2(N);

    logic [N-1:0][WIDTH-1:0] data_q;
    logic [N-1:0]            valid_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [N-1:0]            free;
    logic [N-1:0]            mask;
    logic                    accept;

    // Destination mask: all channels, one channel, or none when out of range
    always_comb begin
        mask = '0;
        if (bus.in_bcast) begin
            mask = '1;
        end else if ({1'b0, bus.in_sel} < (SEL_W + 1)'(N)) begin
            mask = N'(1) << bus.in_sel;
        end
    end

    assign free         = ~valid_q | bus.out_ready;
    assign bus.in_ready = &(free | ~mask);
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.drop_cnt  = cnt_q;

    // Per-channel output registers: load on accept, clear when drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (accept && mask[k]) begin
                    data_q[k]  <= bus.in_data;
                    valid_q[k] <= 1'b1;
                end else if (bus.out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // Saturating count of accepted words that had no destination
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && (mask == '0) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_stream_demux_1xn.sv
// Testbench for stream_demux_1xn: directed spec scenarios plus random traffic
// checked against a per-channel slot model; a second N=6 instance covers drops.
module tb_stream_demux_1xn;
    localparam int W  = 8;
    localparam int N  = 8;
    localparam int N6 = 6;
    localparam int C  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_demux_1xn_if #(.WIDTH(W), .N(N),  .CNT_W(C)) a ();
    stream_demux_1xn_if #(.WIDTH(W), .N(N6), .CNT_W(C)) b ();

    stream_demux_1xn #(.WIDTH(W), .N(N), .CNT_W(C)) dut (
        .clk(clk),
        .rst(rst),
        .bus(a.slave)
    );

    stream_demux_1xn #(.WIDTH(W), .N(N6), .CNT_W(C)) dut6 (
        .clk(clk),
        .rst(rst),
        .bus(b.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model: each channel is a slot that is either empty or holds one word
    logic         m_valid [N];
    logic [W-1:0] m_data  [N];
    logic         last_r;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
        end
    endtask

    // Word can go only if every addressed slot is empty or being emptied now
    function automatic logic model_ready();
        logic r;
        r = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (a.in_bcast || int'(a.in_sel) == k) begin
                if (m_valid[k] && !a.out_ready[k]) r = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic model_step(input logic r);
        for (int k = 0; k < N; k++) begin
            if (r && a.in_valid && (a.in_bcast || int'(a.in_sel) == k)) begin
                m_valid[k] = 1'b1;
                m_data[k]  = a.in_data;
            end else if (a.out_ready[k]) begin
                m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N*W-1:0] ed;
        logic [N-1:0]   ev;
        for (int k = 0; k < N; k++) begin
            ev[k]          = m_valid[k];
            ed[k*W +: W]   = m_data[k];
        end
        chk("out_valid", 64'(a.out_valid), 64'(ev));
        chk("out_data", 64'(a.out_data), 64'(ed));
        chk("drop_cnt8", 64'(a.drop_cnt), 64'd0);
    endtask

    // One clock: inputs were applied at the preceding negedge
    task automatic cycle();
        #1;
        last_r = model_ready();
        chk("in_ready", 64'(a.in_ready), 64'(last_r));
        @(posedge clk);
        if (rst) model_clear();
        else model_step(last_r);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] sel, input logic bc,
                        input logic [W-1:0] d);
        a.in_sel   = sel;
        a.in_bcast = bc;
        a.in_data  = d;
        a.in_valid = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        a.in_data   = '0;
        a.in_sel    = '0;
        a.in_bcast  = 1'b0;
        a.in_valid  = 1'b0;
        a.out_ready = 8'hFF;
        b.in_data   = '0;
        b.in_sel    = '0;
        b.in_bcast  = 1'b0;
        b.in_valid  = 1'b0;
        b.out_ready = '1;
        model_clear();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(a.out_valid), 64'd0);
        chk("rst_data", 64'(a.out_data), 64'd0);
        chk("rst_ready", 64'(a.in_ready), 64'd1);
        chk("rst_drop", 64'(a.drop_cnt), 64'd0);
        rst = 1'b0;

        // Unicast, single-cycle pulse
        send(3'd3, 1'b0, 8'hA5);
        cycle();
        chk("uni_valid", 64'(a.out_valid), 64'h08);
        chk("uni_ch3", 64'(a.out_data[3*W +: W]), 64'hA5);
        a.in_valid = 1'b0;
        cycle();
        chk("uni_gone", 64'(a.out_valid), 64'h00);

        // Asynchronous reset mid-cycle
        send(3'd6, 1'b0, 8'h5A);
        @(posedge clk);
        #1;
        chk("arst_pre", 64'(a.out_valid), 64'h40);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(a.out_valid), 64'd0);
        chk("arst_data", 64'(a.out_data), 64'd0);
        model_clear();
        a.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Backpressure on channel 5
        a.out_ready = 8'hDF;
        send(3'd5, 1'b0, 8'h11);
        cycle();
        chk("bp_ch5", 64'(a.out_data[5*W +: W]), 64'h11);
        send(3'd5, 1'b0, 8'h22);
        #1;
        chk("bp_stall", 64'(a.in_ready), 64'd0);
        cycle();
        chk("bp_hold", 64'(a.out_data[5*W +: W]), 64'h11);
        send(3'd2, 1'b0, 8'h33);
        #1;
        chk("bp_other", 64'(a.in_ready), 64'd1);
        cycle();
        chk("bp_ch2", 64'(a.out_valid), 64'h24);
        a.out_ready = 8'hFF;
        send(3'd5, 1'b0, 8'h22);
        cycle();
        chk("bp_next_v", 64'(a.out_valid), 64'h20);
        chk("bp_next_d", 64'(a.out_data[5*W +: W]), 64'h22);
        a.in_valid = 1'b0;
        cycle();

        // Broadcast blocked by one full channel, then released
        a.out_ready = 8'hFD;
        send(3'd1, 1'b0, 8'h77);
        cycle();
        send(3'd0, 1'b1, 8'h3C);
        #1;
        chk("bc_block", 64'(a.in_ready), 64'd0);
        cycle();
        chk("bc_none_v", 64'(a.out_valid), 64'h02);
        chk("bc_none_d", 64'(a.out_data[1*W +: W]), 64'h77);
        a.out_ready = 8'hFF;
        cycle();
        chk("bc_all_v", 64'(a.out_valid), 64'hFF);
        chk("bc_all_d", 64'(a.out_data), {8{8'h3C}});
        a.in_valid = 1'b0;
        cycle();

        // Drops and saturation on the N=6 instance
        b.in_sel   = 3'd7;
        b.in_data  = 8'(($urandom));
        b.in_valid = 1'b1;
        #1;
        chk("drop_ready", 64'(b.in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("drop_one", 64'(b.drop_cnt), 64'd1);
        repeat (254) @(posedge clk);
        #1;
        chk("drop_255", 64'(b.drop_cnt), 64'd255);
        repeat (45) @(posedge clk);
        #1;
        chk("drop_sat", 64'(b.drop_cnt), 64'd255);
        chk("drop_nov", 64'(b.out_valid), 64'd0);
        chk("drop_rdy2", 64'(b.in_ready), 64'd1);
        @(negedge clk);
        b.in_valid = 1'b0;

        // Reset while three channels are stalled
        a.out_ready = 8'h00;
        for (int i = 0; i < 3; i++) begin
            send(3'(i), 1'b0, 8'(($urandom)));
            cycle();
        end
        chk("mid_pre", 64'(a.out_valid), 64'h07);
        a.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_valid", 64'(a.out_valid), 64'd0);
        chk("mid_drop6", 64'(b.drop_cnt), 64'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        a.out_ready = 8'hFF;
        send(3'd4, 1'b0, 8'h9E);
        cycle();
        chk("mid_uni_v", 64'(a.out_valid), 64'h10);
        chk("mid_uni_d", 64'(a.out_data[4*W +: W]), 64'h9E);
        a.in_valid = 1'b0;
        cycle();

        // Random traffic; a pending word is held until accepted
        last_r = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (!a.in_valid || last_r) begin
                a.in_valid = ($urandom_range(0, 3) != 0);
                a.in_sel   = 3'($urandom_range(0, 7));
                a.in_bcast = ($urandom_range(0, 7) == 0);
                a.in_data  = 8'($urandom);
            end
            a.out_ready = 8'($urandom | $urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
